// File: rtl/ldmx_axil_pkg.sv
// Shared definitions for the AXI-Lite address merger and its downstream clients:
// merger window map, default error read data and the Wishbone client FSM encoding.
package ldmx_axil_pkg;

  localparam int AXIL_WAW = 18;

  // Word-address windows decoded by the merger: (addr & MASK) == ADDR selects a client
  localparam logic [AXIL_WAW-1:0] ADDR_FASTCONTROL = 18'h10000;
  localparam logic [AXIL_WAW-1:0] MASK_FASTCONTROL = 18'h3F000;
  localparam logic [AXIL_WAW-1:0] ADDR_WISHBONE0   = 18'h11000;
  localparam logic [AXIL_WAW-1:0] MASK_WISHBONE0   = 18'h3F000;
  localparam logic [AXIL_WAW-1:0] ADDR_WISHBONE1   = 18'h12000;
  localparam logic [AXIL_WAW-1:0] MASK_WISHBONE1   = 18'h3F000;
  localparam logic [AXIL_WAW-1:0] ADDR_OLINK0      = 18'h20000;
  localparam logic [AXIL_WAW-1:0] MASK_OLINK0      = 18'h30000;
  localparam logic [AXIL_WAW-1:0] ADDR_OLINK1      = 18'h30000;
  localparam logic [AXIL_WAW-1:0] MASK_OLINK1      = 18'h30000;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  function automatic logic in_window(input logic [AXIL_WAW-1:0] addr,
                                     input logic [AXIL_WAW-1:0] base,
                                     input logic [AXIL_WAW-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ldmx_wb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles from zero and flags expiry once the
// count reaches TIMEOUT; holds there until cleared.
module ldmx_wb_timeout #(
  parameter int TIMEOUT = 255,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + TW'(1);
    end
  end

  assign expire = (count == TW'(TIMEOUT));

endmodule

// File: rtl/ldmx_wb_client_bridge.sv
// Merger client for one Wishbone window: each held read/write strobe becomes exactly one
// classic Wishbone cycle, answered by a one-cycle ack with OR-safe read data.
module ldmx_wb_client_bridge
  import ldmx_axil_pkg::*;
#(
  parameter int          WB_AW    = 12,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic             axilClk,
  input  logic             axilRstN,
  input  logic [17:0]      raddr,
  input  logic [17:0]      waddr,
  input  logic [31:0]      wdata,
  input  logic             rstr,
  input  logic             wstr,
  output logic             rack,
  output logic             wack,
  output logic [31:0]      dout,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [WB_AW-1:0] wb_adr,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack,
  input  logic             wb_err,
  output logic [15:0]      errCount
);

  wb_state_t   state;
  logic        r_done;
  logic        w_done;
  logic        last_wr;
  logic        cur_we;
  logic        abort;
  logic [31:0] cap_data;

  logic r_pend;
  logic w_pend;
  logic take_wr;
  logic cur_strobe;
  logic tmo_expire;
  logic unused_addr_bits;

  assign r_pend     = rstr & ~r_done;
  assign w_pend     = wstr & ~w_done;
  assign take_wr    = w_pend & (~r_pend | ~last_wr);
  assign cur_strobe = cur_we ? wstr : rstr;

  assign unused_addr_bits = ^{raddr[17:WB_AW], waddr[17:WB_AW]};

  ldmx_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (axilClk),
    .rst_n  (axilRstN),
    .clear  (state != ST_BUS),
    .enable (state == ST_BUS),
    .expire (tmo_expire)
  );

  always_ff @(posedge axilClk) begin
    if (!axilRstN) begin
      state    <= ST_IDLE;
      r_done   <= 1'b0;
      w_done   <= 1'b0;
      last_wr  <= 1'b0;
      cur_we   <= 1'b0;
      abort    <= 1'b0;
      cap_data <= '0;
      rack     <= 1'b0;
      wack     <= 1'b0;
      dout     <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_o <= '0;
      wb_sel   <= 4'h0;
      errCount <= '0;
    end else begin
      rack <= 1'b0;
      wack <= 1'b0;
      dout <= '0;
      // Done flags re-arm only once the merger has released the strobe
      if (!rstr) r_done <= 1'b0;
      if (!wstr) w_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (r_pend || w_pend) begin
            state    <= ST_BUS;
            cur_we   <= take_wr;
            abort    <= 1'b0;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_sel   <= 4'hF;
            wb_we    <= take_wr;
            wb_adr   <= take_wr ? waddr[WB_AW-1:0] : raddr[WB_AW-1:0];
            wb_dat_o <= take_wr ? wdata : 32'd0;
          end
        end

        ST_BUS: begin
          // A strobe withdrawn mid-cycle still lets the slave finish, but earns no ack
          if (!cur_strobe) abort <= 1'b1;
          if (wb_err || wb_ack || tmo_expire) begin
            state    <= ST_RESP;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= 4'h0;
            wb_adr   <= '0;
            wb_dat_o <= '0;
            if (wb_err || !wb_ack) begin
              cap_data <= ERR_DATA;
              if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
            end else begin
              cap_data <= wb_dat_i;
            end
          end
        end

        ST_RESP: begin
          state   <= ST_IDLE;
          last_wr <= cur_we;
          if (!abort && cur_strobe) begin
            if (cur_we) begin
              wack   <= 1'b1;
              w_done <= 1'b1;
            end else begin
              rack   <= 1'b1;
              dout   <= cap_data;
              r_done <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldmx_wb_client_bridge.sv
// Self-checking bench for ldmx_wb_client_bridge: a scripted Wishbone slave plus a
// transaction-level model of latency, arbitration order, error data and error counting.
module tb_ldmx_wb_client_bridge;

  localparam int TMO = 8;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } ev_t;

  typedef struct {
    logic [11:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } bus_t;

  logic        axilClk = 1'b0;
  logic        axilRstN;
  logic [17:0] raddr, waddr;
  logic [31:0] wdata;
  logic        rstr, wstr;
  logic        rack, wack;
  logic [31:0] dout;
  logic        wb_cyc, wb_stb, wb_we;
  logic [11:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic        wb_ack, wb_err;
  logic [15:0] errCount;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int glitch = 0;
  int cyc_run = 0;
  int last_cyc_len = 0;
  int slave_mode = 0;      // 0 ack, 1 err, 2 silent
  int slave_wait = 0;
  int slave_cnt = 0;
  logic [31:0] slave_rdata = 32'd0;
  logic [15:0] exp_err = 16'd0;
  bit exp_last_wr = 1'b0;

  ev_t  rack_q[$];
  ev_t  wack_q[$];
  bus_t bus_q[$];

  ldmx_wb_client_bridge #(.WB_AW(12), .TIMEOUT(TMO)) dut (
    .axilClk(axilClk), .axilRstN(axilRstN), .raddr(raddr), .waddr(waddr), .wdata(wdata),
    .rstr(rstr), .wstr(wstr), .rack(rack), .wack(wack), .dout(dout),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err), .errCount(errCount)
  );

  always #5 axilClk = ~axilClk;

  always @(posedge axilClk) cyc_n++;

  // Response monitor: logs every ack pulse with its cycle number and data
  always @(negedge axilClk) begin
    if (rack) rack_q.push_back('{cyc_n, dout});
    if (wack) wack_q.push_back('{cyc_n, dout});
    if (!rack && dout !== 32'd0) glitch++;
    if (wb_cyc) cyc_run++;
    else begin
      if (cyc_run > 0) last_cyc_len = cyc_run;
      cyc_run = 0;
    end
  end

  // Wishbone slave: answers after slave_wait wait states, or never when silent
  always @(negedge axilClk) begin
    if (wb_cyc && wb_stb) begin
      if (slave_mode != 2 && slave_cnt == slave_wait) begin
        wb_ack   = (slave_mode == 0);
        wb_err   = (slave_mode == 1);
        wb_dat_i = slave_rdata;
        bus_q.push_back('{wb_adr, wb_dat_o, wb_sel, wb_we});
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
      slave_cnt++;
    end else begin
      wb_ack    = 1'b0;
      wb_err    = 1'b0;
      wb_dat_i  = 32'd0;
      slave_cnt = 0;
    end
  end

  task automatic clear_logs();
    rack_q.delete();
    wack_q.delete();
    bus_q.delete();
  endtask

  // Raise one strobe, wait (bounded) for its ack pulse, then release the strobe
  task automatic run_txn(input bit wr, input logic [17:0] a, input logic [31:0] d,
                         output int t0, output bit got);
    int n0;
    n0 = wr ? wack_q.size() : rack_q.size();
    @(posedge axilClk); #1;
    if (wr) begin waddr = a; wdata = d; wstr = 1'b1; end
    else begin raddr = a; rstr = 1'b1; end
    t0 = cyc_n;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge axilClk);
      if ((wr ? wack_q.size() : rack_q.size()) > n0) got = 1'b1;
    end
    @(posedge axilClk); #1;
    if (wr) wstr = 1'b0; else rstr = 1'b0;
    exp_last_wr = wr;
  endtask

  task automatic test_reset();
    axilRstN = 1'b0;
    repeat (3) @(posedge axilClk);
    @(negedge axilClk);
    total++; if ({wb_cyc, wb_stb, wb_we, wb_sel, rack, wack} !== 9'd0) begin bad++; $display("FAIL reset_ctrl: got %b expected 0", {wb_cyc, wb_stb, wb_we, wb_sel, rack, wack}); end
    total++; if (wb_adr !== 12'd0) begin bad++; $display("FAIL reset_adr: got %h expected 000", wb_adr); end
    total++; if (wb_dat_o !== 32'd0) begin bad++; $display("FAIL reset_dat_o: got %h expected 0", wb_dat_o); end
    total++; if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout: got %h expected 0", dout); end
    total++; if (errCount !== 16'd0) begin bad++; $display("FAIL reset_errcount: got %0d expected 0", errCount); end
    @(posedge axilClk); #1;
    axilRstN = 1'b1;
    exp_err = 16'd0;
    exp_last_wr = 1'b0;
  endtask

  task automatic test_write();
    int t0; bit got; logic [17:0] a; logic [31:0] d; int w;
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      if (k == 0) begin a = 18'h11005; d = 32'hA5A5_0001; w = 0; end
      else begin a = {6'h11, 12'($urandom)}; d = $urandom; w = $urandom_range(0, 4); end
      slave_mode = 0; slave_wait = w;
      run_txn(1'b1, a, d, t0, got);
      repeat (4) @(negedge axilClk);
      total++; if (!got || wack_q.size() != 1) begin bad++; $display("FAIL write_ack_count[%0d]: got %0d expected 1", k, wack_q.size()); end
      else begin
        total++; if (wack_q[0].cyc != t0 + 3 + w) begin bad++; $display("FAIL write_latency[%0d]: got %0d expected %0d", k, wack_q[0].cyc - t0, 3 + w); end
        total++; if (wack_q[0].d !== 32'd0) begin bad++; $display("FAIL write_dout[%0d]: got %h expected 0", k, wack_q[0].d); end
      end
      total++; if (bus_q.size() != 1) begin bad++; $display("FAIL write_bus_count[%0d]: got %0d expected 1", k, bus_q.size()); end
      else begin
        total++; if ({bus_q[0].we, bus_q[0].sel, bus_q[0].adr} !== {1'b1, 4'hF, a[11:0]}) begin bad++; $display("FAIL write_bus_ctrl[%0d]: got we=%b sel=%h adr=%h expected we=1 sel=f adr=%h", k, bus_q[0].we, bus_q[0].sel, bus_q[0].adr, a[11:0]); end
        total++; if (bus_q[0].dat !== d) begin bad++; $display("FAIL write_bus_data[%0d]: got %h expected %h", k, bus_q[0].dat, d); end
      end
    end
  endtask

  task automatic test_read();
    int t0; bit got; logic [17:0] a; int w;
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      if (k == 0) begin a = 18'h12010; slave_rdata = 32'h1234_5678; w = 4; end
      else begin a = {6'h12, 12'($urandom)}; slave_rdata = $urandom | 32'h1; w = $urandom_range(0, 5); end
      slave_mode = 0; slave_wait = w; glitch = 0;
      run_txn(1'b0, a, 32'd0, t0, got);
      repeat (3) @(negedge axilClk);
      total++; if (!got || rack_q.size() != 1) begin bad++; $display("FAIL read_ack_count[%0d]: got %0d expected 1", k, rack_q.size()); end
      else begin
        total++; if (rack_q[0].cyc != t0 + 3 + w) begin bad++; $display("FAIL read_latency[%0d]: got %0d expected %0d", k, rack_q[0].cyc - t0, 3 + w); end
        total++; if (rack_q[0].d !== slave_rdata) begin bad++; $display("FAIL read_data[%0d]: got %h expected %h", k, rack_q[0].d, slave_rdata); end
      end
      total++; if (bus_q.size() != 1 || bus_q[0].adr !== a[11:0] || bus_q[0].we !== 1'b0) begin bad++; $display("FAIL read_bus[%0d]: got n=%0d expected one read of adr %h", k, bus_q.size(), a[11:0]); end
      total++; if (glitch != 0) begin bad++; $display("FAIL read_dout_idle[%0d]: got %0d nonzero cycles expected 0", k, glitch); end
    end
  endtask

  task automatic test_both();
    bit first_wr; int t0; bit got; logic [31:0] d;
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      first_wr = !exp_last_wr;
      d = $urandom; slave_rdata = $urandom;
      slave_mode = 0; slave_wait = $urandom_range(0, 2);
      @(posedge axilClk); #1;
      raddr = {6'h12, 12'($urandom)}; waddr = {6'h11, 12'($urandom)}; wdata = d;
      rstr = 1'b1; wstr = 1'b1;
      repeat (12) @(negedge axilClk);
      @(posedge axilClk); #1;
      rstr = 1'b0; wstr = 1'b0;
      total++; if (wack_q.size() != 1 || rack_q.size() != 1) begin bad++; $display("FAIL both_counts[%0d]: got wack=%0d rack=%0d expected 1/1", r, wack_q.size(), rack_q.size()); end
      else begin
        total++; if ((wack_q[0].cyc < rack_q[0].cyc) != first_wr) begin bad++; $display("FAIL both_order[%0d]: got write_first=%0d expected %0d", r, wack_q[0].cyc < rack_q[0].cyc, first_wr); end
        total++; if (rack_q[0].d !== slave_rdata) begin bad++; $display("FAIL both_rdata[%0d]: got %h expected %h", r, rack_q[0].d, slave_rdata); end
      end
      total++; if (bus_q.size() != 2 || bus_q[0].we !== first_wr) begin bad++; $display("FAIL both_bus[%0d]: got n=%0d expected 2 cycles, first we=%0d", r, bus_q.size(), first_wr); end
      exp_last_wr = !first_wr;
      if (r == 0) begin
        slave_wait = 0;
        run_txn(1'b1, {6'h11, 12'($urandom)}, $urandom, t0, got);
      end
    end
  endtask

  task automatic test_timeout();
    int t0; bit got;
    clear_logs();
    slave_mode = 2;
    run_txn(1'b0, 18'h12020, 32'd0, t0, got);
    exp_err = exp_err + 16'd1;
    total++; if (!got) begin bad++; $display("FAIL tmo_ack: got none expected rack"); end
    else begin
      total++; if (rack_q[0].cyc != t0 + 3 + TMO) begin bad++; $display("FAIL tmo_latency: got %0d expected %0d", rack_q[0].cyc - t0, 3 + TMO); end
      total++; if (rack_q[0].d !== 32'hDEADBEEF) begin bad++; $display("FAIL tmo_data: got %h expected deadbeef", rack_q[0].d); end
    end
    total++; if (last_cyc_len != TMO + 1) begin bad++; $display("FAIL tmo_cyc_len: got %0d expected %0d", last_cyc_len, TMO + 1); end
    total++; if (errCount !== exp_err) begin bad++; $display("FAIL tmo_errcount: got %0d expected %0d", errCount, exp_err); end
    clear_logs();
    slave_mode = 1; slave_wait = 2;
    run_txn(1'b0, 18'h12030, 32'd0, t0, got);
    exp_err = exp_err + 16'd1;
    total++; if (!got || rack_q[0].d !== 32'hDEADBEEF || rack_q[0].cyc != t0 + 5) begin bad++; $display("FAIL err_resp: got ack=%0d data=%h expected deadbeef at +5", got, rack_q.size() > 0 ? rack_q[0].d : 32'd0); end
    total++; if (errCount !== exp_err) begin bad++; $display("FAIL err_errcount: got %0d expected %0d", errCount, exp_err); end
    slave_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit got;
    clear_logs();
    slave_mode = 2;
    @(posedge axilClk); #1;
    raddr = 18'h12044; rstr = 1'b1;
    repeat (4) @(posedge axilClk);
    #1 axilRstN = 1'b0;
    @(posedge axilClk);
    @(negedge axilClk);
    total++; if ({wb_cyc, wb_stb, rack, wack} !== 4'b0) begin bad++; $display("FAIL rstmid_ctrl: got %b expected 0000", {wb_cyc, wb_stb, rack, wack}); end
    total++; if (errCount !== 16'd0) begin bad++; $display("FAIL rstmid_errcount: got %0d expected 0", errCount); end
    @(posedge axilClk); #1;
    axilRstN = 1'b1;
    exp_err = 16'd0; exp_last_wr = 1'b0;
    slave_mode = 0; slave_wait = 1; slave_rdata = $urandom;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge axilClk);
      if (rack_q.size() > 0) got = 1'b1;
    end
    @(posedge axilClk); #1;
    rstr = 1'b0;
    total++; if (!got || rack_q.size() != 1 || rack_q[0].d !== slave_rdata) begin bad++; $display("FAIL rstmid_newread: got n=%0d expected one rack with %h", rack_q.size(), slave_rdata); end
  endtask

  task automatic test_drop();
    int t0; bit got;
    clear_logs();
    slave_mode = 0; slave_wait = 5; slave_rdata = 32'hCAFE_0001;
    @(posedge axilClk); #1;
    raddr = 18'h12050; rstr = 1'b1;
    repeat (3) @(posedge axilClk);
    #1 rstr = 1'b0;
    repeat (15) @(negedge axilClk);
    total++; if (rack_q.size() != 0) begin bad++; $display("FAIL drop_no_ack: got %0d expected 0", rack_q.size()); end
    total++; if (bus_q.size() != 1 || last_cyc_len != 6) begin bad++; $display("FAIL drop_bus_done: got n=%0d len=%0d expected 1 cycle of 6", bus_q.size(), last_cyc_len); end
    exp_last_wr = 1'b0;
    clear_logs();
    slave_wait = 1; slave_rdata = $urandom;
    run_txn(1'b0, 18'h12050, 32'd0, t0, got);
    total++; if (!got || rack_q[0].d !== slave_rdata || rack_q[0].cyc != t0 + 4) begin bad++; $display("FAIL drop_rearm: got ack=%0d expected fresh read of %h at +4", got, slave_rdata); end
  endtask

  initial begin
    raddr = '0; waddr = '0; wdata = '0; rstr = 1'b0; wstr = 1'b0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_timeout();
    test_reset_mid();
    test_drop();
    repeat (3) @(negedge axilClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
